instr_fetch: RTL

Instruction fetch unit on the CPU side of the instruction-memory interface. It drives `instrmem_addr`, captures the word returned on `instrmem_data`, and hands {pc, instruction} pairs to decode through a valid/ready handshake. A 2-entry prefetch buffer absorbs decode stalls without losing words. Branch/jump redirects flush the buffer and restart fetch at a new PC.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buf.sv | 62 ++++++
 rtl/instr_fetch.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry prefetch FIFO of {pc, instr} entries with flush.
// DEPTH must be a power of two so the pointers wrap by their own width.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       push_entry,
    output fetch_entry_t       head_entry,
    output logic [CNT_W-1:0]   count
);

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Entry storage: written at the tail on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy update; flush empties the buffer outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head reads zero when empty so downstream never sees stale content.
    always_comb begin
        head_entry = '0;
        if (count != '0) begin
            head_entry = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction-memory address, buffers
// returned words and hands {pc, instr} pairs to decode via valid/ready.
// Optional delivered-instruction counter built when INSTR_FETCH_STAT_EN
// is defined; otherwise stat_count is tied to zero.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  instrmem_addr,
    input  logic [INSTR_W-1:0] instrmem_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [31:0]        stat_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic              pop;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Handshake: a full buffer still accepts a word when the head leaves.
    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid && out_ready;
        push       = !redirect_valid && ((count < CNT_W'(DEPTH)) || pop);
        push_entry = '{pc: pc, instr: instrmem_data};
        out_pc     = head_entry.pc;
        out_instr  = head_entry.instr;
    end

    // Fetch PC: redirect wins over sequential advance; wraps modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (push) begin
            pc <= pc + PC_STEP;
        end
    end

    assign instrmem_addr = pc;

    fetch_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .count      (count)
    );

`ifdef INSTR_FETCH_STAT_EN
    logic [31:0] stat_q;

    // Delivered-instruction counter; a pop coinciding with redirect counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else if (pop) begin
            stat_q <= stat_q + 32'd1;
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = 32'h0;
`endif

endmodule
